// File: rtl/cpu_regfile.sv
// Architectural register block for the Nandy CPU: general registers with two read
// ports, a sequenced stack pointer with sticky flags, carry, output latch and input sync.
module cpu_regfile #(
    parameter int               WIDTH       = 8,
    parameter int               NREGS       = 4,
    parameter int               AW          = $clog2(NREGS),
    parameter logic [WIDTH-1:0] SP_RESET    = '0,
    parameter logic [WIDTH-1:0] SP_LIMIT    = {1'b1, {(WIDTH-1){1'b0}}},
    parameter int               BYPASS      = 1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       sp_op,
    input  logic [WIDTH-1:0] sp_load,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] sp_addr,
    output logic             sp_ovf,
    output logic             sp_unf,
    input  logic             flag_clr,
    input  logic             carry_we,
    input  logic             carry_in,
    output logic             carry,
    input  logic             out_we,
    input  logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] ioout,
    input  logic [WIDTH-1:0] ioin,
    output logic [WIDTH-1:0] ioin_q
);

    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_LOAD = 2'b11
    } sp_op_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             carry_q;
    logic [WIDTH-1:0] ioout_q;
    logic             wr_ok;
    sp_op_e           op;

    // Addresses past the last register are legal encodings when NREGS is not a power of two.
    assign wr_ok = (int'(wr_addr) < NREGS);
    assign op    = sp_op_e'(sp_op);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // through the branches leaves it unassigned and a latch is never inferred.
        ra_data = '0;
        if (int'(ra_addr) < NREGS) ra_data = regs_q[ra_addr];
        if ((BYPASS != 0) && wr_en && wr_ok && (wr_addr == ra_addr)) ra_data = wr_data;
    end

    always_comb begin
        rb_data = '0;
        if (int'(rb_addr) < NREGS) rb_data = regs_q[rb_addr];
        if ((BYPASS != 0) && wr_en && wr_ok && (wr_addr == rb_addr)) rb_data = wr_data;
    end

    // sp_addr is the only output that sees sp_op combinationally; sp itself is registered.
    always_comb begin
        sp_d    = sp_q;
        sp_addr = sp_q;
        ovf_d   = ovf_q & ~flag_clr;
        unf_d   = unf_q & ~flag_clr;
        case (op)
            SP_PUSH: begin
                sp_d    = sp_q - ONE;
                sp_addr = sp_q - ONE;
                if (sp_q == SP_LIMIT) ovf_d = 1'b1;
            end
            SP_POP: begin
                sp_d = sp_q + ONE;
                if (sp_q == SP_RESET) unf_d = 1'b1;
            end
            SP_LOAD: sp_d = sp_load;
            default: ;
        endcase
    end

    // NOTE: the register array is reset explicitly because architectural state must
    // read 0 after reset; this forces flops rather than a RAM macro, which is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en && wr_ok) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= SP_RESET;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            carry_q <= 1'b0;
            ioout_q <= '0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (carry_we) carry_q <= carry_in;
            if (out_we)   ioout_q <= out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ioin;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sp     = sp_q;
    assign sp_ovf = ovf_q;
    assign sp_unf = unf_q;
    assign carry  = carry_q;
    assign ioout  = ioout_q;
    assign ioin_q = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_cpu_regfile.sv
// Bench for cpu_regfile: a bypassing 4-register instance and a non-bypassing
// 3-register instance share stimulus; expectations flow through a scoreboard queue.
module tb_cpu_regfile;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   ra_addr, rb_addr, wr_addr, sp_op;
    logic         wr_en, flag_clr, carry_we, carry_in, out_we;
    logic [W-1:0] wr_data, sp_load, out_data, ioin;

    logic [W-1:0] ra_data, rb_data, sp, sp_addr, ioout, ioin_q;
    logic         sp_ovf, sp_unf, carry;

    logic [W-1:0] nb_ra_data, nb_rb_data, nb_sp, nb_sp_addr, nb_ioout, nb_ioin_q;
    logic         nb_sp_ovf, nb_sp_unf, nb_carry;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] val;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] na;
        logic [7:0] nb;
    } vec_t;
    vec_t vecs[7];

    cpu_regfile u_dut (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sp_op(sp_op), .sp_load(sp_load), .sp(sp), .sp_addr(sp_addr),
        .sp_ovf(sp_ovf), .sp_unf(sp_unf), .flag_clr(flag_clr),
        .carry_we(carry_we), .carry_in(carry_in), .carry(carry),
        .out_we(out_we), .out_data(out_data), .ioout(ioout),
        .ioin(ioin), .ioin_q(ioin_q)
    );

    cpu_regfile #(.NREGS(3), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(nb_ra_data), .rb_addr(rb_addr), .rb_data(nb_rb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sp_op(sp_op), .sp_load(sp_load), .sp(nb_sp), .sp_addr(nb_sp_addr),
        .sp_ovf(nb_sp_ovf), .sp_unf(nb_sp_unf), .flag_clr(flag_clr),
        .carry_we(carry_we), .carry_in(carry_in), .carry(nb_carry),
        .out_we(out_we), .out_data(out_data), .ioout(nb_ioout),
        .ioin(ioin), .ioin_q(nb_ioin_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic sb_push(input string name, input logic [W-1:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [W-1:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got %02h expected none", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.val);
        end
    endtask

    // Expectation queued at drive time, compared once the output is observable.
    task automatic expect_now(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        sb_push(name, exp);
        sb_pop(act);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
        ra_addr = 2'd0; rb_addr = 2'd0;
        sp_op = 2'b00; sp_load = '0; flag_clr = 1'b0;
        carry_we = 1'b0; carry_in = 1'b0; out_we = 1'b0; out_data = '0;
    endtask

    initial begin
        //            we    wa    wd     ra    rb    ea     eb     na     nb
        vecs[0] = {1'b1, 2'd0, 8'h11, 2'd0, 2'd1, 8'h11, 8'h00, 8'h00, 8'h00};
        vecs[1] = {1'b1, 2'd1, 8'h22, 2'd0, 2'd1, 8'h11, 8'h22, 8'h11, 8'h00};
        vecs[2] = {1'b1, 2'd2, 8'hA5, 2'd2, 2'd0, 8'hA5, 8'h11, 8'h00, 8'h11};
        vecs[3] = {1'b1, 2'd3, 8'hF0, 2'd1, 2'd2, 8'h22, 8'hA5, 8'h22, 8'hA5};
        vecs[4] = {1'b0, 2'd0, 8'h77, 2'd3, 2'd0, 8'hF0, 8'h11, 8'h00, 8'h11};
        vecs[5] = {1'b1, 2'd3, 8'h0F, 2'd3, 2'd3, 8'h0F, 8'h0F, 8'h00, 8'h00};
        vecs[6] = {1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 8'h0F, 8'hA5, 8'h00, 8'hA5};

        rst_n = 1'b0;
        ioin  = '0;
        idle();

        // Reset held while inputs toggle randomly.
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 8'($urandom_range(0, 255));
            sp_op    = 2'($urandom_range(0, 3));
            sp_load  = 8'($urandom_range(0, 255));
            carry_we = 1'($urandom_range(0, 1));
            carry_in = 1'($urandom_range(0, 1));
            out_we   = 1'($urandom_range(0, 1));
            out_data = 8'($urandom_range(0, 255));
            ioin     = 8'($urandom_range(0, 255));
        end
        tick();
        idle();
        ioin  = '0;
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            ra_addr = 2'(a);
            #0.1;
            expect_now("reset_reg", ra_data, 8'h00);
        end
        ra_addr = 2'd0;
        expect_now("reset_sp", sp, 8'h00);
        expect_now("reset_sp_addr", sp_addr, 8'h00);
        expect_now("reset_ovf", {7'd0, sp_ovf}, 8'h00);
        expect_now("reset_unf", {7'd0, sp_unf}, 8'h00);
        expect_now("reset_carry", {7'd0, carry}, 8'h00);
        expect_now("reset_ioout", ioout, 8'h00);
        expect_now("reset_ioin_q", ioin_q, 8'h00);

        // Table-driven write/read/bypass vectors on both instances.
        tick();
        for (int i = 0; i < 7; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            ra_addr = vecs[i].ra;
            rb_addr = vecs[i].rb;
            sb_push($sformatf("vec%0d_ra", i), vecs[i].ea);
            sb_push($sformatf("vec%0d_rb", i), vecs[i].eb);
            sb_push($sformatf("vec%0d_nb_ra", i), vecs[i].na);
            sb_push($sformatf("vec%0d_nb_rb", i), vecs[i].nb);
            @(negedge clk);
            sb_pop(ra_data);
            sb_pop(rb_data);
            sb_pop(nb_ra_data);
            sb_pop(nb_rb_data);
            tick();
        end
        idle();

        // Stack sequence from sp=00.
        sp_op = 2'b01;
        @(negedge clk); expect_now("push1_addr", sp_addr, 8'hFF);
        tick();         expect_now("push1_sp", sp, 8'hFF);
        @(negedge clk); expect_now("push2_addr", sp_addr, 8'hFE);
        tick();         expect_now("push2_sp", sp, 8'hFE);
        sp_op = 2'b10;
        @(negedge clk); expect_now("pop1_addr", sp_addr, 8'hFE);
        tick();         expect_now("pop1_sp", sp, 8'hFF);
        tick();         expect_now("pop2_sp", sp, 8'h00);
        expect_now("pop2_unf", {7'd0, sp_unf}, 8'h00);
        @(negedge clk); expect_now("pop3_addr", sp_addr, 8'h00);
        tick();         expect_now("pop3_sp", sp, 8'h01);
        expect_now("pop3_unf", {7'd0, sp_unf}, 8'h01);
        sp_op = 2'b00; flag_clr = 1'b1;
        tick();         expect_now("unf_clr", {7'd0, sp_unf}, 8'h00);
        flag_clr = 1'b0;

        // Overflow at SP_LIMIT, set-wins against flag_clr, then clear.
        sp_op = 2'b11; sp_load = 8'h80;
        @(negedge clk); expect_now("load_addr", sp_addr, 8'h01);
        tick();         expect_now("load_sp", sp, 8'h80);
        expect_now("load_no_ovf", {7'd0, sp_ovf}, 8'h00);
        sp_op = 2'b01;
        tick();         expect_now("ovf_sp", sp, 8'h7F);
        expect_now("ovf_set", {7'd0, sp_ovf}, 8'h01);
        sp_op = 2'b11;
        tick();
        sp_op = 2'b01; flag_clr = 1'b1;
        tick();         expect_now("ovf_set_wins", {7'd0, sp_ovf}, 8'h01);
        sp_op = 2'b00;
        tick();         expect_now("ovf_clr", {7'd0, sp_ovf}, 8'h00);
        flag_clr = 1'b0;

        // All enables in one cycle.
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h5C;
        carry_we = 1'b1; carry_in = 1'b1;
        out_we = 1'b1; out_data = 8'h3C;
        sp_op = 2'b10;
        tick();
        idle();
        ra_addr = 2'd1;
        #1;
        expect_now("simul_reg", ra_data, 8'h5C);
        expect_now("simul_carry", {7'd0, carry}, 8'h01);
        expect_now("simul_ioout", ioout, 8'h3C);
        expect_now("simul_sp", sp, 8'h80);
        carry_we = 1'b1; carry_in = 1'b0;
        tick();
        carry_we = 1'b0;
        expect_now("carry_clr", {7'd0, carry}, 8'h00);

        // Input synchroniser latency and async reset mid-pipeline.
        ioin = 8'h5A;
        tick();         expect_now("sync_edge1", ioin_q, 8'h00);
        tick();         expect_now("sync_edge2", ioin_q, 8'h5A);
        ioin = 8'hC3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_ioin_q", ioin_q, 8'h00);
        expect_now("async_ioout", ioout, 8'h00);
        expect_now("async_sp", sp, 8'h00);
        expect_now("async_reg", ra_data, 8'h00);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        expect_now("reset_drops_write", ra_data, 8'h00);
        wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        #1;
        expect_now("first_write_after_reset", ra_data, 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
